// File: rtl/fetch_if.sv
// Fetch-stage bus: pipeline control inputs, instruction-memory port and IF/ID outputs.
interface fetch_if;
    logic       stall;
    logic       redirect_en;
    logic [7:0] redirect_pc;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] if_pc;
    logic [7:0] if_instr;
    logic [7:0] if_imm;
    logic       if_valid;
    logic       if_flush;

    // Fetch unit side.
    modport master (
        input  stall,
        input  redirect_en,
        input  redirect_pc,
        input  imem_data,
        output imem_addr,
        output if_pc,
        output if_instr,
        output if_imm,
        output if_valid,
        output if_flush
    );

    // Pipeline / memory side.
    modport slave (
        output stall,
        output redirect_en,
        output redirect_pc,
        output imem_data,
        input  imem_addr,
        input  if_pc,
        input  if_instr,
        input  if_imm,
        input  if_valid,
        input  if_flush
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, assembles 1/2-byte instructions, handles the
// reset vector, HALT and downstream redirects. Outputs are combinational from state
// and the same-cycle instruction-memory byte.
module fetch_unit #(
    parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
    parameter logic [3:0] IMM_OPCODE     = 4'hC,
    parameter logic [7:0] HALT_OPCODE    = 8'h01
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus_io
);

    typedef enum logic [1:0] {
        StVec,
        StFetch,
        StImm,
        StHalted
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] op_hold_q, op_hold_d;
    logic [7:0] pc_hold_q, pc_hold_d;

    logic       is_imm_op;
    logic       is_halt_op;
    logic       redirect;
    logic [7:0] pc_inc;

    assign is_imm_op  = (bus_io.imem_data[7:4] == IMM_OPCODE);
    assign is_halt_op = (bus_io.imem_data == HALT_OPCODE);
    // The reset-vector load cannot be interrupted by a redirect.
    assign redirect   = bus_io.redirect_en && (state_q != StVec);
    assign pc_inc     = pc_q + 8'd1;

    // Output decode: memory address and the instruction presented to IF/ID.
    always_comb begin
        bus_io.imem_addr = pc_q;
        bus_io.if_pc     = 8'h00;
        bus_io.if_instr  = 8'h00;
        bus_io.if_imm    = 8'h00;
        bus_io.if_valid  = 1'b0;
        bus_io.if_flush  = 1'b0;
        unique case (state_q)
            StVec: begin
                bus_io.imem_addr = RESET_VEC_ADDR;
            end
            StFetch: begin
                if (redirect) begin
                    bus_io.if_flush = 1'b1;
                end else if (!is_imm_op) begin
                    // Plain 1-byte instruction, or HALT presented once.
                    bus_io.if_valid = 1'b1;
                    bus_io.if_pc    = pc_q;
                    bus_io.if_instr = bus_io.imem_data;
                end
            end
            StImm: begin
                if (redirect) begin
                    bus_io.if_flush = 1'b1;
                end else begin
                    bus_io.if_valid = 1'b1;
                    bus_io.if_pc    = pc_hold_q;
                    bus_io.if_instr = op_hold_q;
                    bus_io.if_imm   = bus_io.imem_data;
                end
            end
            StHalted: begin
                bus_io.if_flush = redirect;
            end
            default: begin
                bus_io.imem_addr = pc_q;
            end
        endcase
    end

    // Next-state: redirect beats stall; stall freezes everything else.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_hold_d = op_hold_q;
        pc_hold_d = pc_hold_q;
        if (state_q == StVec) begin
            pc_d    = bus_io.imem_data;
            state_d = StFetch;
        end else if (redirect) begin
            // Any half-assembled opcode is simply abandoned.
            pc_d    = bus_io.redirect_pc;
            state_d = StFetch;
        end else if (!bus_io.stall) begin
            unique case (state_q)
                StFetch: begin
                    if (is_imm_op) begin
                        op_hold_d = bus_io.imem_data;
                        pc_hold_d = pc_q;
                        pc_d      = pc_inc;
                        state_d   = StImm;
                    end else if (is_halt_op) begin
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                StImm: begin
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: begin
                    state_d = StVec;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StVec;
            pc_q      <= 8'h00;
            op_hold_q <= 8'h00;
            pc_hold_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_hold_q <= op_hold_d;
            pc_hold_q <= pc_hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/reset traffic
// over a random program image, checked cycle by cycle against a behavioural model.
module tb_fetch_unit;

    localparam logic [7:0] ResetVec = 8'h00;
    localparam logic [3:0] ImmOp    = 4'hC;
    localparam logic [7:0] HaltOp   = 8'h01;

    logic clk = 1'b0;
    logic rst;

    fetch_if bus ();

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    // Model: "started" = reset vector consumed, "halted", "have_op" = opcode waiting
    // for its immediate byte.
    bit         m_started;
    bit         m_halted;
    bit         m_have_op;
    logic [7:0] m_pc;
    logic [7:0] m_op;
    logic [7:0] m_op_pc;

    logic [7:0] last_addr, last_pc, last_instr, last_imm;
    logic       last_valid, last_flush;

    always #5 clk = ~clk;

    // Combinational instruction memory.
    assign bus.imem_data = mem[bus.imem_addr];

    fetch_unit #(
        .RESET_VEC_ADDR(ResetVec),
        .IMM_OPCODE    (ImmOp),
        .HALT_OPCODE   (HaltOp)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_have_op = 1'b0;
        m_pc      = 8'h00;
        m_op      = 8'h00;
        m_op_pc   = 8'h00;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic do_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_en = 1'b0;
        #1;
        check_eq("rst_addr", bus.imem_addr, ResetVec);
        check_eq("rst_valid", 8'(bus.if_valid), 8'h00);
        check_eq("rst_flush", 8'(bus.if_flush), 8'h00);
        check_eq("rst_pc", bus.if_pc, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive, compare against the model, advance the model at the edge.
    task automatic step(input logic s, input logic r, input logic [7:0] rp);
        logic [7:0] d;
        logic [7:0] e_addr, e_pc, e_instr, e_imm;
        logic       e_valid, e_flush;
        bus.stall       = s;
        bus.redirect_en = r;
        bus.redirect_pc = rp;
        #1;
        e_addr  = 8'h00;
        e_pc    = 8'h00;
        e_instr = 8'h00;
        e_imm   = 8'h00;
        e_valid = 1'b0;
        e_flush = 1'b0;
        if (!m_started) begin
            e_addr = ResetVec;
            d      = mem[ResetVec];
        end else begin
            e_addr = m_pc;
            d      = mem[m_pc];
            if (r) begin
                e_flush = 1'b1;
            end else if (m_halted) begin
                e_valid = 1'b0;
            end else if (m_have_op) begin
                e_valid = 1'b1;
                e_pc    = m_op_pc;
                e_instr = m_op;
                e_imm   = d;
            end else if (d[7:4] != ImmOp) begin
                e_valid = 1'b1;
                e_pc    = m_pc;
                e_instr = d;
            end
        end
        check_eq("imem_addr", bus.imem_addr, e_addr);
        check_eq("if_valid", 8'(bus.if_valid), 8'(e_valid));
        check_eq("if_flush", 8'(bus.if_flush), 8'(e_flush));
        check_eq("if_pc", bus.if_pc, e_pc);
        check_eq("if_instr", bus.if_instr, e_instr);
        check_eq("if_imm", bus.if_imm, e_imm);
        last_addr  = bus.imem_addr;
        last_pc    = bus.if_pc;
        last_instr = bus.if_instr;
        last_imm   = bus.if_imm;
        last_valid = bus.if_valid;
        last_flush = bus.if_flush;
        @(posedge clk);
        if (!m_started) begin
            m_pc      = d;
            m_started = 1'b1;
        end else if (r) begin
            m_pc      = rp;
            m_halted  = 1'b0;
            m_have_op = 1'b0;
        end else if (s || m_halted) begin
            m_pc = m_pc;
        end else if (m_have_op) begin
            m_have_op = 1'b0;
            m_pc      = m_pc + 8'd1;
        end else if (d[7:4] == ImmOp) begin
            m_have_op = 1'b1;
            m_op      = d;
            m_op_pc   = m_pc;
            m_pc      = m_pc + 8'd1;
        end else if (d == HaltOp) begin
            m_halted = 1'b1;
        end else begin
            m_pc = m_pc + 8'd1;
        end
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        int unsigned r;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 8'h00;
        model_reset();
        clear_mem();
        @(negedge clk);

        // 1: reset vector then first plain instruction.
        mem[8'h00] = 8'h10;
        mem[8'h10] = 8'h22;
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        check_eq("t1_vec_valid", 8'(last_valid), 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t1_pc", last_pc, 8'h10);
        check_eq("t1_instr", last_instr, 8'h22);
        check_eq("t1_valid", 8'(last_valid), 8'h01);

        // 2: two-byte instruction.
        mem[8'h10] = 8'hC3;
        mem[8'h11] = 8'h5A;
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t2_c1_valid", 8'(last_valid), 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t2_pc", last_pc, 8'h10);
        check_eq("t2_instr", last_instr, 8'hC3);
        check_eq("t2_imm", last_imm, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t2_next_pc", last_addr, 8'h12);

        // 3: stall for three cycles in the immediate phase.
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            check_eq("t3_stall_addr", last_addr, 8'h11);
            check_eq("t3_stall_imm", last_imm, 8'h5A);
        end
        step(1'b0, 1'b0, 8'h00);
        check_eq("t3_done_instr", last_instr, 8'hC3);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t3_next_pc", last_addr, 8'h12);

        // 4: redirect with simultaneous stall during the immediate phase.
        mem[8'h40] = 8'h33;
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h40);
        check_eq("t4_flush", 8'(last_flush), 8'h01);
        check_eq("t4_valid", 8'(last_valid), 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t4_pc", last_pc, 8'h40);
        check_eq("t4_instr", last_instr, 8'h33);
        check_eq("t4_imm", last_imm, 8'h00);

        // 5: immediate wraps from 8'hFF to 8'h00.
        clear_mem();
        mem[8'h00] = 8'h99;
        mem[8'hFF] = 8'hC7;
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t5_pc", last_pc, 8'hFF);
        check_eq("t5_imm", last_imm, 8'h99);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t5_next_pc", last_addr, 8'h01);

        // 6: HALT, resume by redirect, reset while halted.
        clear_mem();
        mem[8'h00] = 8'h20;
        mem[8'h20] = HaltOp;
        mem[8'h30] = 8'h44;
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t6_halt_valid", 8'(last_valid), 8'h01);
        check_eq("t6_halt_instr", last_instr, HaltOp);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check_eq("t6_halted_valid", 8'(last_valid), 8'h00);
            check_eq("t6_halted_pc", last_addr, 8'h20);
        end
        step(1'b0, 1'b1, 8'h30);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t6_resume_instr", last_instr, 8'h44);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        do_reset();

        // Randomized program and control traffic.
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(99, 0);
            if (r < 25) mem[i] = {ImmOp, 4'($urandom)};
            else if (r < 28) mem[i] = HaltOp;
            else mem[i] = 8'($urandom);
        end
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(99, 0);
            if (r == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(3, 0) == 0), ($urandom_range(9, 0) == 0), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
